// File: rtl/wb_lane_serializer.sv
// wb_lane_serializer
// Writeback-side output stage for the SIMD FIR core. Captures every result
// written to OUT_REG, buffers up to DEPTH words and serializes each word lane
// by lane (lane 0 first) onto a valid/ready sample stream. The pipeline is
// never stalled: a capture that finds the buffer full is dropped and the
// sticky overflow flag is raised.
// Optional feature: define WB_SER_COUNT_EN to add the 32-bit word_count port,
// which counts fully serialized words.
module wb_lane_serializer #(
  parameter int         DATA_W  = 256,
  parameter int         LANE_W  = 16,
  parameter int         DEPTH   = 2,
  parameter logic [4:0] OUT_REG = 5'd31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [4:0]        RdW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
`ifdef WB_SER_COUNT_EN
  ,
  output logic [31:0]       word_count
`endif
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // Word storage viewed as lanes so the output mux is a plain index
  logic [LANES-1:0][LANE_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LIDX_W-1:0] lidx_q, lidx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic captureHit;
  logic outValid;
  logic lastLane;
  logic xfer;
  logic popWord;
  logic push;
  logic drop;

  // Handshake decode and next-state for pointers, lane index, fill count and
  // the sticky overflow flag. A full buffer still accepts a capture when the
  // head word's final lane leaves in the same cycle, freeing its slot.
  always_comb begin
    captureHit = RegWriteW && (RdW == OUT_REG);
    outValid   = (count_q != '0);
    lastLane   = (lidx_q == LIDX_W'(LANES - 1));
    xfer       = outValid && out_ready;
    popWord    = xfer && lastLane;
    push       = captureHit && ((count_q != CNT_W'(DEPTH)) || popWord);
    drop       = captureHit && !push;

    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    lidx_d     = lidx_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    end

    if (xfer) begin
      if (lastLane) begin
        lidx_d  = '0;
        rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
      end else begin
        lidx_d = lidx_q + LIDX_W'(1);
      end
    end

    case ({push, popWord})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      lidx_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      lidx_q     <= lidx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage: cleared on reset, written at wrPtr on an accepted capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wrPtr_q] <= ResultW;
    end
  end

`ifdef WB_SER_COUNT_EN
  logic [31:0] wordCount_q;

  // Count completed words; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      wordCount_q <= '0;
    end else if (popWord) begin
      wordCount_q <= wordCount_q + 32'd1;
    end
  end

  assign word_count = wordCount_q;
`endif

  assign out_valid = outValid;
  assign busy      = outValid;
  assign out_last  = outValid && lastLane;
  assign out_data  = mem_q[rdPtr_q][lidx_q];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_lane_serializer.sv
// tb_wb_lane_serializer
// Self-checking bench for wb_lane_serializer at default parameters. A queue of
// buffered words plus a lane index forms the reference model; directed
// scenarios are followed by a randomized phase.
module tb_wb_lane_serializer;

  logic         clk;
  logic         rst;
  logic         RegWriteW;
  logic [4:0]   RdW;
  logic [255:0] ResultW;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         overflow;
`ifdef WB_SER_COUNT_EN
  logic [31:0]  word_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [255:0] modelQ [$];
  int           modelLane = 0;
  logic         modelOvf = 1'b0;
  logic [31:0]  modelWc = '0;

  wb_lane_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
`ifdef WB_SER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value to its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model before the
  // edge, then advance the model by the rules for that edge
  task automatic applyStimulus(input logic rstV, input logic rwe, input logic [4:0] rd,
                               input logic [255:0] res, input logic rdy);
    logic         expValid;
    logic         capture;
    logic         accept;
    logic [255:0] head;
    int           sizeBefore;
    rst       = rstV;
    RegWriteW = rwe;
    RdW       = rd;
    ResultW   = res;
    out_ready = rdy;

    expValid = (modelQ.size() != 0);
    checkOutput("valid", {31'd0, out_valid}, {31'd0, expValid});
    checkOutput("busy", {31'd0, busy}, {31'd0, expValid});
    checkOutput("last", {31'd0, out_last}, {31'd0, expValid && (modelLane == 15)});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, modelOvf});
    if (expValid) begin
      head = modelQ[0];
      checkOutput("data", {16'd0, out_data}, {16'd0, head[modelLane*16 +: 16]});
    end
`ifdef WB_SER_COUNT_EN
    checkOutput("wordCount", word_count, modelWc);
`endif

    @(posedge clk);
    if (rstV) begin
      modelQ.delete();
      modelLane = 0;
      modelOvf  = 1'b0;
      modelWc   = '0;
    end else begin
      sizeBefore = modelQ.size();
      capture    = rwe && (rd == 5'd31);
      accept     = capture && ((sizeBefore < 2) ||
                               (expValid && rdy && modelLane == 15));
      if (expValid && rdy) begin
        if (modelLane == 15) begin
          void'(modelQ.pop_front());
          modelLane = 0;
          modelWc   = modelWc + 32'd1;
        end else begin
          modelLane++;
        end
      end
      if (accept) modelQ.push_back(res);
      else if (capture) modelOvf = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [255:0] rampWord(input logic [15:0] base);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = base + 16'(i);
    return w;
  endfunction

  function automatic logic [255:0] randWord();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, '0, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b0);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset then idle
    doReset();
    checkOutput("rstData", {16'd0, out_data}, 32'd0);
    idle(2, 1'b0);

    // Single capture with ready high, then drain
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'h1000), 1'b1);
    idle(18, 1'b1);

    // Non-matching writes: wrong register, and right register without enable
    applyStimulus(1'b0, 1'b1, 5'd5, randWord(), 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd31, randWord(), 1'b1);
    idle(2, 1'b1);

    // Backpressure pattern 1,0,0,1 then drain
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'h2000), 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1);
    idle(16, 1'b1);

    // Overflow: A, B fill the buffer, C is dropped; then release
    doReset();
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'hA000), 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'hB000), 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'hC000), 1'b0);
    idle(2, 1'b0);
    idle(34, 1'b1);

    // Full buffer, head at lane 15 popping while a capture arrives
    doReset();
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'h3000), 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'h4000), 1'b0);
    idle(15, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd31, rampWord(16'h5000), 1'b1);
    idle(34, 1'b1);

    // Reset mid-word aborts serialization
    applyStimulus(1'b0, 1'b1, 5'd31, randWord(), 1'b1);
    idle(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd31, randWord(), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic       we;
      logic [4:0] rd;
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 3) != 0) ? 5'd31 : 5'($urandom_range(0, 31));
      applyStimulus(r, we, rd, randWord(), ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
